// File: rtl/bp_be_fp_unbox_recode_pkg.sv
// Shared floating-point format constants and the stage-1 operand record
// used by the unbox/recode pipeline.
package bp_be_fp_unbox_recode_pkg;

  // IEEE binary32 / binary64 field widths (significand includes hidden bit)
  localparam int sp_w     = 32;
  localparam int dp_w     = 64;
  localparam int sp_exp_w = 8;
  localparam int sp_sig_w = 24;
  localparam int dp_exp_w = 11;
  localparam int dp_sig_w = 53;

  // Recoded widths: sign + (exp_w+1) exponent + (sig_w-1) fraction
  localparam int sp_rec_w = sp_exp_w + sp_sig_w + 1;
  localparam int dp_rec_w = dp_exp_w + dp_sig_w + 1;

  // Stored fraction widths and leading-zero count widths
  localparam int sp_fw = sp_sig_w - 1;
  localparam int dp_fw = dp_sig_w - 1;
  localparam int sp_dw = $clog2(sp_sig_w);
  localparam int dp_dw = $clog2(dp_sig_w);

  // Value substituted for an SP operand that is not NaN-boxed
  localparam logic [sp_w-1:0] sp_box_nan = 32'h7fc0_0000;

  // Canonical quiet NaN in DP recoded form
  localparam logic [dp_rec_w-1:0] dp_rec_nan = 65'h0_e008_0000_0000_0000;

  // Recoded exponent offset between SP and DP: 2^11 - 2^8
  localparam logic [dp_exp_w:0] sp_to_dp_exp_bias = 12'h700;

  // Per-operand stage-1 record
  typedef struct packed {
    logic [dp_w-1:0] val;
    logic            box_fail;
  } unbox_t;

  // SP operands must carry all-ones in the upper half; anything else is
  // replaced by the canonical SP NaN and flagged. DP passes untouched.
  function automatic unbox_t unbox(input logic [dp_w-1:0] raw, input logic sp);
    unbox_t r;
    r.val      = raw;
    r.box_fail = 1'b0;
    if (sp) begin
      if (&raw[dp_w-1:sp_w]) begin
        r.val = {{(dp_w-sp_w){1'b1}}, raw[sp_w-1:0]};
      end else begin
        r.val      = {{(dp_w-sp_w){1'b1}}, sp_box_nan};
        r.box_fail = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_be_fp_unbox_recode_if.sv
// Operand-set bus of the unbox/recode block.
// Handshake: on each side a transfer happens on a rising clock edge where
// valid and ready are both high. A producer keeps valid and payload stable
// until the transfer; ready never depends combinationally on valid.
interface bp_be_fp_unbox_recode_if
  import bp_be_fp_unbox_recode_pkg::*;
#(
  parameter int els_p       = 3,
  parameter int tag_width_p = 8
);
  logic                         v_i;
  logic                         ready_o;
  logic [els_p*dp_w-1:0]        data_i;
  logic                         sp_i;
  logic [tag_width_p-1:0]       tag_i;
  logic                         v_o;
  logic                         ready_and_i;
  logic [els_p*dp_rec_w-1:0]    rec_o;
  logic [els_p-1:0]             box_fail_o;
  logic [tag_width_p-1:0]       tag_o;

  modport master (
    output v_i, data_i, sp_i, tag_i, ready_and_i,
    input  ready_o, v_o, rec_o, box_fail_o, tag_o
  );

  modport slave (
    input  v_i, data_i, sp_i, tag_i, ready_and_i,
    output ready_o, v_o, rec_o, box_fail_o, tag_o
  );
endinterface

// File: rtl/bp_be_fp_recode_el.sv
// Per-operand recode: IEEE DP -> recoded DP, or IEEE SP -> recoded SP
// followed by exact widening to recoded DP.
module bp_be_fp_recode_el
  import bp_be_fp_unbox_recode_pkg::*;
(
  input  logic [dp_w-1:0]     val,
  input  logic                sp,
  output logic [dp_rec_w-1:0] rec
);

  function automatic logic [dp_rec_w-1:0] recode_dp(input logic [dp_w-1:0] f);
    logic [dp_exp_w-1:0] exp_in;
    logic [dp_fw-1:0]    fract, sub_fract;
    logic [dp_dw-1:0]    norm_dist;
    logic [dp_exp_w:0]   adj_exp, bias, exp_out;
    logic                zero_exp, zero_fract;
    exp_in     = f[dp_w-2 -: dp_exp_w];
    fract      = f[dp_fw-1:0];
    zero_exp   = (exp_in == '0);
    zero_fract = (fract == '0);
    norm_dist  = '0;
    for (int i = 0; i < dp_fw; i++) begin
      if (fract[i]) norm_dist = dp_dw'(dp_fw - 1 - i);
    end
    sub_fract = (fract << norm_dist) << 1;
    bias = '0;
    bias[dp_exp_w-1] = 1'b1;
    if (zero_exp) bias[1] = 1'b1;
    else          bias[0] = 1'b1;
    adj_exp = zero_exp ? ~{{(dp_exp_w+1-dp_dw){1'b0}}, norm_dist} : {1'b0, exp_in};
    adj_exp = adj_exp + bias;
    if (zero_exp && zero_fract)         exp_out = '0;
    else if (adj_exp[dp_exp_w -: 2] == 2'b11)
      exp_out = {2'b11, ~zero_fract, adj_exp[dp_exp_w-3:0]};
    else                                exp_out = adj_exp;
    return {f[dp_w-1], exp_out, zero_exp ? sub_fract : fract};
  endfunction

  function automatic logic [sp_rec_w-1:0] recode_sp(input logic [sp_w-1:0] f);
    logic [sp_exp_w-1:0] exp_in;
    logic [sp_fw-1:0]    fract, sub_fract;
    logic [sp_dw-1:0]    norm_dist;
    logic [sp_exp_w:0]   adj_exp, bias, exp_out;
    logic                zero_exp, zero_fract;
    exp_in     = f[sp_w-2 -: sp_exp_w];
    fract      = f[sp_fw-1:0];
    zero_exp   = (exp_in == '0);
    zero_fract = (fract == '0);
    norm_dist  = '0;
    for (int i = 0; i < sp_fw; i++) begin
      if (fract[i]) norm_dist = sp_dw'(sp_fw - 1 - i);
    end
    sub_fract = (fract << norm_dist) << 1;
    bias = '0;
    bias[sp_exp_w-1] = 1'b1;
    if (zero_exp) bias[1] = 1'b1;
    else          bias[0] = 1'b1;
    adj_exp = zero_exp ? ~{{(sp_exp_w+1-sp_dw){1'b0}}, norm_dist} : {1'b0, exp_in};
    adj_exp = adj_exp + bias;
    if (zero_exp && zero_fract)         exp_out = '0;
    else if (adj_exp[sp_exp_w -: 2] == 2'b11)
      exp_out = {2'b11, ~zero_fract, adj_exp[sp_exp_w-3:0]};
    else                                exp_out = adj_exp;
    return {f[sp_w-1], exp_out, zero_exp ? sub_fract : fract};
  endfunction

  // Every SP recoded value is representable in DP recoded form: specials
  // keep their 3-bit class code, finite values shift the exponent bias and
  // the fraction (including any NaN payload) is left-aligned.
  function automatic logic [dp_rec_w-1:0] widen_sp(input logic [sp_rec_w-1:0] r);
    logic [sp_exp_w:0] e;
    logic [dp_exp_w:0] e_out;
    e = r[sp_rec_w-2 -: sp_exp_w+1];
    case (e[sp_exp_w -: 3])
      3'b000:         e_out = '0;
      3'b110, 3'b111: e_out = {e[sp_exp_w -: 3], {(dp_exp_w-2){1'b0}}};
      default:        e_out = {{(dp_exp_w-sp_exp_w){1'b0}}, e} + sp_to_dp_exp_bias;
    endcase
    return {r[sp_rec_w-1], e_out, r[sp_fw-1:0], {(dp_fw-sp_fw){1'b0}}};
  endfunction

  // Select the precision path for this operand
  always_comb begin
    rec = recode_dp(val);
    if (sp) rec = widen_sp(recode_sp(val[sp_w-1:0]));
  end

endmodule

// File: rtl/bp_be_fp_unbox_recode.sv
// Two-stage pipeline: stage 1 registers unboxed operands, stage 2 registers
// the DP-recoded result. Elastic valid/ready, one set per cycle.
module bp_be_fp_unbox_recode
  import bp_be_fp_unbox_recode_pkg::*;
#(
  parameter int els_p       = 3,
  parameter int tag_width_p = 8
)
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_be_fp_unbox_recode_if.slave io
);

  unbox_t [els_p-1:0]          s1_in, s1_ops;
  logic                        s1_v, s1_sp;
  logic [tag_width_p-1:0]      s1_tag;
  logic                        s2_v;
  logic [els_p*dp_rec_w-1:0]   s2_rec, rec_next;
  logic [els_p-1:0]            s2_fail, fail_next;
  logic [tag_width_p-1:0]      s2_tag;
  logic                        s1_adv, s2_adv, in_xfer, ready;

  for (genvar k = 0; k < els_p; k++) begin : g_el
    assign s1_in[k]     = unbox(io.data_i[k*dp_w +: dp_w], io.sp_i);
    assign fail_next[k] = s1_ops[k].box_fail;
    bp_be_fp_recode_el u_recode (
      .val (s1_ops[k].val),
      .sp  (s1_sp),
      .rec (rec_next[k*dp_rec_w +: dp_rec_w])
    );
  end

  // Stage 2 drains on an output transfer; stage 1 moves when stage 2 frees
  assign s2_adv  = s2_v & io.ready_and_i;
  assign s1_adv  = s1_v & (~s2_v | s2_adv);
  assign ready   = ~s1_v | s1_adv;
  assign in_xfer = io.v_i & ready;

  assign io.ready_o    = ready;
  assign io.v_o        = s2_v;
  assign io.rec_o      = s2_rec;
  assign io.box_fail_o = s2_fail;
  assign io.tag_o      = s2_tag;

  // Stage valid bits: the only reset state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (in_xfer)     s1_v <= 1'b1;
      else if (s1_adv) s1_v <= 1'b0;
      if (s1_adv)      s2_v <= 1'b1;
      else if (s2_adv) s2_v <= 1'b0;
    end
  end

  // Stage payload registers load alongside their valid bit
  always_ff @(posedge clk_i) begin
    if (in_xfer) begin
      s1_ops <= s1_in;
      s1_sp  <= io.sp_i;
      s1_tag <= io.tag_i;
    end
    if (s1_adv) begin
      s2_rec  <= rec_next;
      s2_fail <= fail_next;
      s2_tag  <= s1_tag;
    end
  end

endmodule
